// File: rtl/uart_xcvr_param_if.sv
// Host-side bundle for the UART transceiver: transmit handshake, receive
// status and the two serial pins.
interface uart_xcvr_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 trmt;
    logic [DATA_BITS-1:0] tx_data;
    logic                 TX;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 RX;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rdy;
    logic                 clr_rdy;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport slave (
        input  trmt, tx_data, RX, clr_rdy,
        output TX, tx_busy, tx_done, rx_data, rdy, parity_err, frame_err, overrun
    );

    modport master (
        output trmt, tx_data, RX, clr_rdy,
        input  TX, tx_busy, tx_done, rx_data, rdy, parity_err, frame_err, overrun
    );
endinterface

// File: rtl/uart_xcvr_param.sv
// Full-duplex UART with configurable width, divisor, parity and stop bits.
// Independent TX and RX state machines; RX reports parity/framing/overrun.
module uart_xcvr_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BAUD_DIV   = 2604,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input logic               clk,
    input logic               rst,
    uart_xcvr_param_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             ODD       = 1'(PARITY_ODD);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_baud_q, tx_baud_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;

    state_e               rx_state_q, rx_state_d;
    logic [1:0]           rx_sync_q, rx_sync_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rdy_q, rdy_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_s;

    assign rx_s = rx_sync_q[1];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = tx_done_q;
        if (tx_state_q == S_IDLE) begin
            if (bus.trmt) begin
                tx_state_d = S_START;
                tx_baud_d  = '0;
                tx_shift_d = bus.tx_data;
                tx_par_d   = (^bus.tx_data) ^ ODD;
                tx_d       = 1'b0;
                tx_busy_d  = 1'b1;
                tx_done_d  = 1'b0;
            end
        end else if (tx_baud_q != BAUD_LAST) begin
            tx_baud_d = tx_baud_q + CNT_ONE;
        end else begin
            tx_baud_d = '0;
            unique case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
                S_DATA: begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_state_d = S_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = S_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
                S_PARITY: begin
                    tx_state_d = S_STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
                S_STOP: begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = S_IDLE;
                        tx_busy_d  = 1'b0;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                    tx_d = 1'b1;
                end
                default: tx_state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_sync_d   = {rx_sync_q[0], bus.RX};
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        rx_data_d   = rx_data_q;
        rdy_d       = rdy_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        ovr_d       = ovr_q;
        if (bus.clr_rdy) begin
            rdy_d  = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (rx_state_q == S_IDLE) begin
            if (!rx_s) begin
                rx_state_d  = S_START;
                rx_cnt_d    = BAUD_HALF;
                rx_bit_d    = '0;
                rx_par_d    = 1'b0;
                perr_pend_d = 1'b0;
                ferr_pend_d = 1'b0;
            end
        end else if (rx_cnt_q != CNT_ONE) begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else begin
            // Sample point: counter expiring marks the centre of the current bit.
            rx_cnt_d = BAUD_FULL;
            unique case (rx_state_q)
                S_START: rx_state_d = rx_s ? S_IDLE : S_DATA;
                S_DATA: begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_par_d   = rx_par_q ^ rx_s;
                    if (rx_bit_q == DATA_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    perr_pend_d = rx_par_q ^ rx_s ^ ODD;
                    rx_state_d  = S_STOP;
                    rx_bit_d    = '0;
                end
                S_STOP: begin
                    ferr_pend_d = ferr_pend_q | ~rx_s;
                    if (rx_bit_q == STOP_LAST) begin
                        // Completion overrides a same-cycle clr_rdy.
                        rx_state_d = S_IDLE;
                        rx_data_d  = rx_shift_q;
                        rdy_d      = 1'b1;
                        ovr_d      = rdy_q & ~bus.clr_rdy;
                        perr_d     = perr_pend_q;
                        ferr_d     = ferr_pend_q | ~rx_s;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_baud_q   <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_state_q  <= S_IDLE;
            rx_sync_q   <= '1;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_q    <= 1'b0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            rx_data_q   <= '0;
            rdy_q       <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
            rx_state_q  <= rx_state_d;
            rx_sync_q   <= rx_sync_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_q    <= rx_par_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            rx_data_q   <= rx_data_d;
            rdy_q       <= rdy_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.TX         = tx_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rdy        = rdy_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed bench: 8N1 loopback, 7O1 loopback with parity forcing, and an
// 8N2 receiver driven bit-by-bit from the bench. BAUD_DIV=16 throughout.
module tb_uart_xcvr_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    logic force1;
    logic rx2;
    int   errors = 0;
    int   checks = 0;
    int   cyc, rcyc;

    uart_xcvr_param_if #(.DATA_BITS(8)) b0 ();
    uart_xcvr_param_if #(.DATA_BITS(7)) b1 ();
    uart_xcvr_param_if #(.DATA_BITS(8)) b2 ();

    assign b0.RX = b0.TX;
    assign b1.RX = b1.TX & ~force1;
    assign b2.RX = rx2;

    uart_xcvr_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst0), .bus(b0));
    uart_xcvr_param #(.DATA_BITS(7), .BAUD_DIV(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        u1 (.clk(clk), .rst(rst1), .bus(b1));
    uart_xcvr_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u2 (.clk(clk), .rst(rst2), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Launches a frame on u0 and waits (bounded) for tx_done; glitch_at>0
    // pulses trmt with different data at that cycle of the frame.
    task automatic send0(input logic [7:0] d, input int glitch_at,
                         output int done_cyc, output int rdy_cyc);
        b0.tx_data = d;
        b0.trmt    = 1'b1;
        tick(1);
        b0.trmt  = 1'b0;
        done_cyc = 0;
        rdy_cyc  = 0;
        chk("tx_busy_after_trmt", {31'b0, b0.tx_busy}, 32'd1);
        while (!b0.tx_done && done_cyc < 400) begin
            tick(1);
            done_cyc++;
            b0.trmt = (done_cyc == glitch_at);
            if (done_cyc == glitch_at) b0.tx_data = 8'hFF;
            if (b0.rdy && rdy_cyc == 0) rdy_cyc = done_cyc;
        end
        b0.trmt = 1'b0;
    endtask

    task automatic drive2(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx2 = bits[i];
            tick(16);
        end
        rx2 = 1'b1;
    endtask

    task automatic clr_all();
        b0.clr_rdy = 1'b1;
        b1.clr_rdy = 1'b1;
        b2.clr_rdy = 1'b1;
        tick(1);
        b0.clr_rdy = 1'b0;
        b1.clr_rdy = 1'b0;
        b2.clr_rdy = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        force1 = 1'b0; rx2 = 1'b1;
        b0.trmt = 1'b0; b0.tx_data = '0; b0.clr_rdy = 1'b0;
        b1.trmt = 1'b0; b1.tx_data = '0; b1.clr_rdy = 1'b0;
        b2.trmt = 1'b0; b2.tx_data = '0; b2.clr_rdy = 1'b0;
        tick(3);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // Reset / idle
        chk("rst_TX", {31'b0, b0.TX}, 32'd1);
        chk("rst_tx_busy", {31'b0, b0.tx_busy}, 32'd0);
        chk("rst_tx_done", {31'b0, b0.tx_done}, 32'd0);
        chk("rst_rdy", {31'b0, b0.rdy}, 32'd0);
        chk("rst_flags", {29'b0, b0.parity_err, b0.frame_err, b0.overrun}, 32'd0);
        chk("rst_rx_data", {24'b0, b0.rx_data}, 32'h00);
        chk("rst_TX_u1", {31'b0, b1.TX}, 32'd1);
        chk("rst_rdy_u2", {31'b0, b2.rdy}, 32'd0);
        tick(5);

        // 8N1 loopback, 0x00 then 0x76
        send0(8'h00, 0, cyc, rcyc);
        chk("lb0_done_cycles", cyc, 32'd160);
        chk("lb0_rx_data", {24'b0, b0.rx_data}, 32'h00);
        chk("lb0_rdy_before_done", {31'b0, (rcyc > 0 && rcyc < cyc)}, 32'd1);
        chk("lb0_flags", {29'b0, b0.parity_err, b0.frame_err, b0.overrun}, 32'd0);
        clr_all();
        send0(8'h76, 0, cyc, rcyc);
        chk("lb1_done_cycles", cyc, 32'd160);
        chk("lb1_rx_data", {24'b0, b0.rx_data}, 32'h76);
        chk("lb1_rdy_before_done", {31'b0, (rcyc > 0 && rcyc < cyc)}, 32'd1);
        chk("lb1_flags", {29'b0, b0.parity_err, b0.frame_err, b0.overrun}, 32'd0);
        clr_all();
        chk("clr_rdy", {31'b0, b0.rdy}, 32'd0);

        // trmt mid-frame is ignored
        send0(8'h5A, 40, cyc, rcyc);
        chk("glitch_done_cycles", cyc, 32'd160);
        chk("glitch_rx_data", {24'b0, b0.rx_data}, 32'h5A);
        clr_all();

        // Overrun
        send0(8'h12, 0, cyc, rcyc);
        send0(8'h34, 0, cyc, rcyc);
        chk("ovr_rx_data", {24'b0, b0.rx_data}, 32'h34);
        chk("ovr_rdy", {31'b0, b0.rdy}, 32'd1);
        chk("ovr_flag", {31'b0, b0.overrun}, 32'd1);
        clr_all();
        chk("ovr_clr_rdy", {31'b0, b0.rdy}, 32'd0);
        chk("ovr_clr_flag", {31'b0, b0.overrun}, 32'd0);

        // Reset mid-frame (TX and looped-back RX)
        b0.tx_data = 8'h81;
        b0.trmt = 1'b1;
        tick(1);
        b0.trmt = 1'b0;
        tick(50);
        chk("mid_TX_busy", {31'b0, b0.tx_busy}, 32'd1);
        rst0 = 1'b1;
        tick(1);
        rst0 = 1'b0;
        chk("midrst_TX", {31'b0, b0.TX}, 32'd1);
        chk("midrst_busy", {31'b0, b0.tx_busy}, 32'd0);
        tick(200);
        chk("midrst_no_rdy", {31'b0, b0.rdy}, 32'd0);
        chk("midrst_no_done", {31'b0, b0.tx_done}, 32'd0);

        // 7O1 loopback: 0x55 has four ones, so the odd parity bit is 1
        b1.tx_data = 7'h55;
        b1.trmt = 1'b1;
        tick(1);
        b1.trmt = 1'b0;
        tick(136);
        chk("par_bit_TX", {31'b0, b1.TX}, 32'd1);
        tick(24);
        chk("par_tx_done", {31'b0, b1.tx_done}, 32'd1);
        chk("par_rdy", {31'b0, b1.rdy}, 32'd1);
        chk("par_rx_data", {25'b0, b1.rx_data}, 32'h55);
        chk("par_err_clean", {31'b0, b1.parity_err}, 32'd0);
        clr_all();
        b1.trmt = 1'b1;
        tick(1);
        b1.trmt = 1'b0;
        tick(128);
        force1 = 1'b1;
        tick(16);
        force1 = 1'b0;
        tick(16);
        chk("parf_rdy", {31'b0, b1.rdy}, 32'd1);
        chk("parf_err", {31'b0, b1.parity_err}, 32'd1);
        chk("parf_rx_data", {25'b0, b1.rx_data}, 32'h55);
        chk("parf_ferr", {31'b0, b1.frame_err}, 32'd0);

        // 8N2: second stop bit low
        drive2({5'b0, 1'b0, 1'b1, 8'hA5, 1'b0}, 11);
        tick(40);
        chk("stop2_rdy", {31'b0, b2.rdy}, 32'd1);
        chk("stop2_ferr", {31'b0, b2.frame_err}, 32'd1);
        chk("stop2_rx_data", {24'b0, b2.rx_data}, 32'hA5);
        chk("stop2_perr_ovr", {30'b0, b2.parity_err, b2.overrun}, 32'd0);
        clr_all();

        // False start: 4-cycle low pulse
        rx2 = 1'b0;
        tick(4);
        rx2 = 1'b1;
        tick(40);
        chk("fstart_no_rdy", {31'b0, b2.rdy}, 32'd0);
        chk("fstart_no_ferr", {31'b0, b2.frame_err}, 32'd0);
        drive2({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        tick(20);
        chk("after_fstart_rdy", {31'b0, b2.rdy}, 32'd1);
        chk("after_fstart_data", {24'b0, b2.rx_data}, 32'h3C);
        chk("after_fstart_ferr", {31'b0, b2.frame_err}, 32'd0);
        clr_all();

        // Break: constant low line
        rx2 = 1'b0;
        tick(250);
        chk("break_rdy", {31'b0, b2.rdy}, 32'd1);
        chk("break_ferr", {31'b0, b2.frame_err}, 32'd1);
        chk("break_rx_data", {24'b0, b2.rx_data}, 32'h00);
        rx2 = 1'b1;
        tick(300);
        clr_all();
        drive2({5'b0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11);
        tick(20);
        chk("after_break_rdy", {31'b0, b2.rdy}, 32'd1);
        chk("after_break_data", {24'b0, b2.rx_data}, 32'hC3);
        chk("after_break_ferr", {31'b0, b2.frame_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_xcvr_param.md
Name: uart_xcvr_param

Overview:
Parametrised full-duplex UART transceiver. Combines the TX and RX functions into one block and generalises them in data width, baud divisor, parity and stop-bit count. Adds receive error reporting (parity, framing, overrun) and false-start rejection. Sits between on-chip command/telemetry logic and the board-level serial pins; loopback (TX tied to RX) is the primary verification configuration.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9, sent LSB first
BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud), legal >= 8
PARITY_EN, 0, 1 = append/check a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 1, stop bits transmitted and checked, legal 1 or 2

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
trmt  in  1  one-cycle pulse: start transmitting tx_data
tx_data  in  DATA_BITS  payload to send, captured on trmt
TX  out  1  serial output, idle high
tx_busy  out  1  high from the cycle after an accepted trmt to the end of the last stop bit
tx_done  out  1  set at end of frame; held until the next accepted trmt
RX  in  1  serial input, asynchronous
rx_data  out  DATA_BITS  last received payload
rdy  out  1  new rx_data available; held until clr_rdy
clr_rdy  in  1  clears rdy, parity_err, frame_err, overrun
parity_err  out  1  parity mismatch on the frame that set rdy
frame_err  out  1  a stop bit was sampled low on the frame that set rdy
overrun  out  1  a frame completed while rdy was already 1

Behaviour:
- Reset values (rst high at a clk edge): TX=1, tx_busy=0, tx_done=0, rx_data=0, rdy=0, parity_err=0, frame_err=0, overrun=0, RX synchroniser flops=1, both FSMs in IDLE, all counters 0. Reset mid-frame aborts immediately: TX returns high the next cycle and no rdy is produced.
- Frame format: start(0), DATA_BITS data LSB first, optional parity, then STOP_BITS ones. Frame length is N = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, trmt=1 captures tx_data into a shift register, clears tx_done and sets tx_busy. TX=0 from the next cycle.
  - Each bit lasts exactly BAUD_DIV cycles (baud counter reloads per bit). The bit counter selects the next state.
  - Parity is XOR of the data bits, inverted when PARITY_ODD=1.
  - After the last stop bit completes: tx_busy=0, tx_done=1, back to IDLE.
  - trmt while tx_busy is ignored; tx_data is not re-sampled mid-frame.
  - Back-to-back: trmt in the same cycle the FSM re-enters IDLE is accepted.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - RX passes through a 2-flop synchroniser before any use.
  - In IDLE, synchronised RX=0 moves the FSM to START and loads the counter with BAUD_DIV/2 (integer division).
  - At mid-start the line is sampled. If high, it is a false start: return to IDLE with no flags changed. If low, the counter reloads BAUD_DIV and each later bit is sampled at its centre.
  - At the centre of the final stop bit:
    - rx_data is updated and rdy=1.
    - parity_err and frame_err are set from the frame's checks; every stop bit is checked.
    - overrun=1 if rdy was already 1; the new data overwrites rx_data.
    - The FSM returns to IDLE at once, so the next start edge can be detected half a bit early.
  - A frame with frame_err still sets rdy.
- clr_rdy in the same cycle as frame completion: completion wins. rdy=1, overrun is not set, and the error flags reflect the new frame.
- With a constant 0 on RX, the RX FSM reports frame_err, then re-enters START on the next sample of 0 (break condition); no lockup.
- TX and RX are fully independent; simultaneous operation is required.

Test Plan:
1. Reset / idle: BAUD_DIV=16, defaults, hold rst 3 cycles -> TX=1, rdy=0, tx_done=0, all error flags 0.
2. Loopback 8N1: TX tied to RX, send 0x00 then 0x76 -> each tx_done exactly 160 clocks after trmt. rx_data=0x00 then 0x76, rdy=1 before tx_done, no error flags.
3. Parity: DATA_BITS=7, PARITY_EN=1, PARITY_ODD=1, send 0x55 -> parity bit on TX=1, rx_data=0x55, parity_err=0. Then force the parity bit low on RX -> parity_err=1, rdy=1.
4. Framing and false start:
   - STOP_BITS=2, drive RX low during the second stop bit -> frame_err=1.
   - Pulse RX low for 4 cycles only -> no rdy, FSM returns to IDLE.
5. Overrun: receive 0x12, do not assert clr_rdy, receive 0x34 -> rx_data=0x34, overrun=1. One clr_rdy -> rdy=0, overrun=0.
6. Mid-frame behaviour:
   - Assert trmt again mid-frame -> ignored, frame unchanged.
   - Assert rst mid-TX-frame -> TX=1 the next cycle, tx_busy=0.
   - Assert rst mid-RX-frame -> no rdy.
